// File: rtl/pitch_cmd_builder.sv
// PITCH byte-stream parser that frames messages and builds 312-bit OrderBook commands.
// Optional statistics counters are enabled by the PITCH_STATS_EN macro.
module pitch_cmd_builder (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [311:0] out_command,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  stat_parsed,
  output logic [31:0]  stat_dropped,
  output logic [31:0]  stat_unknown
);
  localparam int unsigned CMD_W  = 312;
  localparam int unsigned STAT_W = 32;

  localparam logic [7:0] T_ADD    = 8'h21;
  localparam logic [7:0] T_EXEC   = 8'h23;
  localparam logic [7:0] T_REDUCE = 8'h25;
  localparam logic [7:0] T_MODIFY = 8'h27;
  localparam logic [7:0] T_DELETE = 8'h29;

  typedef enum logic [1:0] {ST_LEN, ST_TYPE, ST_BODY, ST_SKIP} state_e;

  // Expected total length for a known type; 0 marks an unknown type.
  function automatic logic [7:0] exp_len(input logic [7:0] t);
    case (t)
      T_ADD:    return 8'd34;
      T_EXEC:   return 8'd26;
      T_REDUCE: return 8'd18;
      T_MODIFY: return 8'd27;
      T_DELETE: return 8'd14;
      default:  return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] cmd_code(input logic [7:0] t);
    case (t)
      T_EXEC:   return 8'd1;
      T_REDUCE: return 8'd2;
      T_MODIFY: return 8'd3;
      T_DELETE: return 8'd4;
      default:  return 8'd0;
    endcase
  endfunction

  function automatic logic in_rng(input logic [7:0] c, input logic [7:0] lo, input logic [7:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d, len_q, len_d, type_q, type_d, side_q, side_d;
  logic [63:0]        oid_q, oid_d, price_q, price_d;
  logic [47:0]        sym_q, sym_d;
  logic [31:0]        qty_q, qty_d, exec_q, exec_d, canc_q, canc_d;
  logic [CMD_W-1:0]   out_command_q, out_command_d;
  logic               out_valid_q, out_valid_d;
  logic               byte_acc, last_byte, emit, drop_ev, unk_ev;

  assign in_ready    = ~out_valid_q | out_ready;
  assign out_valid   = out_valid_q;
  assign out_command = out_command_q;
  assign byte_acc    = in_valid & in_ready;
  assign last_byte   = (cnt_q == len_q - 8'd1);

  // Fields are little-endian, so each byte shifts in from the top.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    type_d        = type_q;
    oid_d         = oid_q;
    side_d        = side_q;
    qty_d         = qty_q;
    sym_d         = sym_q;
    price_d       = price_q;
    exec_d        = exec_q;
    canc_d        = canc_q;
    out_valid_d   = out_valid_q & ~out_ready;
    out_command_d = out_command_q;
    emit          = 1'b0;
    drop_ev       = 1'b0;
    unk_ev        = 1'b0;
    if (byte_acc) begin
      case (state_q)
        ST_LEN: begin
          cnt_d = 8'd0;
          if (in_data < 8'd2) drop_ev = 1'b1;
          else begin
            len_d   = in_data;
            state_d = ST_TYPE;
          end
        end
        ST_TYPE: begin
          type_d  = in_data;
          cnt_d   = 8'd2;
          oid_d   = '0;
          side_d  = '0;
          qty_d   = '0;
          sym_d   = '0;
          price_d = '0;
          exec_d  = '0;
          canc_d  = '0;
          state_d = (len_q == 8'd2) ? ST_LEN : ST_SKIP;
          if (exp_len(in_data) == 8'd0) unk_ev = 1'b1;
          else if (exp_len(in_data) != len_q) drop_ev = 1'b1;
          else if (len_q != 8'd2) state_d = ST_BODY;
        end
        ST_BODY: begin
          if (in_rng(cnt_q, 8'd6, 8'd13)) oid_d = {in_data, oid_q[63:8]};
          case (type_q)
            T_ADD: begin
              if (cnt_q == 8'd14) side_d = in_data;
              if (in_rng(cnt_q, 8'd15, 8'd18)) qty_d = {in_data, qty_q[31:8]};
              if (in_rng(cnt_q, 8'd19, 8'd24)) sym_d = {in_data, sym_q[47:8]};
              if (in_rng(cnt_q, 8'd25, 8'd32)) price_d = {in_data, price_q[63:8]};
            end
            T_EXEC:   if (in_rng(cnt_q, 8'd14, 8'd17)) exec_d = {in_data, exec_q[31:8]};
            T_REDUCE: if (in_rng(cnt_q, 8'd14, 8'd17)) canc_d = {in_data, canc_q[31:8]};
            T_MODIFY: begin
              if (in_rng(cnt_q, 8'd14, 8'd17)) qty_d = {in_data, qty_q[31:8]};
              if (in_rng(cnt_q, 8'd18, 8'd25)) price_d = {in_data, price_q[63:8]};
            end
            default: ;
          endcase
          if (last_byte) begin
            state_d = ST_LEN;
            cnt_d   = 8'd0;
            if (type_q == T_ADD && side_q != 8'h42 && side_q != 8'h53) drop_ev = 1'b1;
            else emit = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_SKIP: begin
          if (last_byte) begin
            state_d = ST_LEN;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = ST_LEN;
      endcase
    end
    if (emit) begin
      out_valid_d   = 1'b1;
      out_command_d = {8'h00, cmd_code(type_q), side_d, oid_d, qty_d, {16'h0000, sym_d},
                       price_d, exec_d, canc_d};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_LEN;
      cnt_q         <= '0;
      len_q         <= '0;
      type_q        <= '0;
      oid_q         <= '0;
      side_q        <= '0;
      qty_q         <= '0;
      sym_q         <= '0;
      price_q       <= '0;
      exec_q        <= '0;
      canc_q        <= '0;
      out_valid_q   <= 1'b0;
      out_command_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      type_q        <= type_d;
      oid_q         <= oid_d;
      side_q        <= side_d;
      qty_q         <= qty_d;
      sym_q         <= sym_d;
      price_q       <= price_d;
      exec_q        <= exec_d;
      canc_q        <= canc_d;
      out_valid_q   <= out_valid_d;
      out_command_q <= out_command_d;
    end
  end

`ifdef PITCH_STATS_EN
  logic [STAT_W-1:0] stat_parsed_q, stat_parsed_d;
  logic [STAT_W-1:0] stat_dropped_q, stat_dropped_d;
  logic [STAT_W-1:0] stat_unknown_q, stat_unknown_d;

  // At most one event fires per accepted byte; counters wrap naturally.
  always_comb begin
    stat_parsed_d  = stat_parsed_q + STAT_W'(emit);
    stat_dropped_d = stat_dropped_q + STAT_W'(drop_ev);
    stat_unknown_d = stat_unknown_q + STAT_W'(unk_ev);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_parsed_q  <= '0;
      stat_dropped_q <= '0;
      stat_unknown_q <= '0;
    end else begin
      stat_parsed_q  <= stat_parsed_d;
      stat_dropped_q <= stat_dropped_d;
      stat_unknown_q <= stat_unknown_d;
    end
  end

  assign stat_parsed  = stat_parsed_q;
  assign stat_dropped = stat_dropped_q;
  assign stat_unknown = stat_unknown_q;
`else
  logic stats_unused;
  assign stats_unused = drop_ev ^ unk_ev;
  assign stat_parsed  = '0;
  assign stat_dropped = '0;
  assign stat_unknown = '0;
`endif

endmodule

// File: tb/tb_pitch_cmd_builder.sv
// Scoreboard bench for pitch_cmd_builder; stat expectations follow PITCH_STATS_EN.
module tb_pitch_cmd_builder;
  logic         clk;
  logic         reset_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [311:0] out_command;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  stat_parsed, stat_dropped, stat_unknown;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;
  logic [311:0] sb[$];
  logic [7:0]   msg[$];

  pitch_cmd_builder dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_command(out_command), .out_valid(out_valid),
    .out_ready(out_ready), .stat_parsed(stat_parsed), .stat_dropped(stat_dropped),
    .stat_unknown(stat_unknown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [311:0] act, input logic [311:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic [31:0] v);
`ifdef PITCH_STATS_EN
    return v;
`else
    return 32'(v & 32'h0);
`endif
  endfunction

  function automatic logic [311:0] mk_cmd(input logic [7:0] ct, input logic [7:0] side,
      input logic [63:0] oid, input logic [31:0] qty, input logic [47:0] sym,
      input logic [63:0] price, input logic [31:0] ex, input logic [31:0] cn);
    return {8'h00, ct, side, oid, qty, 16'h0000, sym, price, ex, cn};
  endfunction

  task automatic push_le(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) msg.push_back(v[8*i +: 8]);
  endtask

  task automatic hdr(input logic [7:0] l, input logic [7:0] t);
    msg.delete();
    msg.push_back(l);
    msg.push_back(t);
    push_le(64'($urandom), 4);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int n;
    ok = 0;
    n  = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!ok && n < 1000) begin
      #1 ok = in_ready;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (!ok) check_val("send_timeout", 312'(ok), 312'(1));
  endtask

  task automatic send_msg(input int nbytes);
    for (int i = 0; i < nbytes; i++) send_byte(msg[i]);
  endtask

  task automatic mk_add(input logic [63:0] oid, input logic [7:0] side, input logic [31:0] qty,
                        input logic [47:0] sym, input logic [63:0] price);
    hdr(8'd34, 8'h21);
    push_le(oid, 8);
    msg.push_back(side);
    push_le(64'(qty), 4);
    push_le(64'(sym), 6);
    push_le(price, 8);
    msg.push_back(8'h5a);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard consumer: handshake is sampled mid-low-phase, before the next rising edge.
  always begin
    @(negedge clk);
    #3;
    if (reset_n && out_valid && out_ready) begin
      xfers++;
      if (sb.size() == 0) check_val("out_unexpected", 312'(sb.size()), 312'(1));
      else check_val("sb_cmd", out_command, sb.pop_front());
    end
  end

  initial begin
    logic [311:0] held;
    int x0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check_val("rst_in_ready", 312'(in_ready), 312'(1));
    check_val("rst_out_valid", 312'(out_valid), 312'(0));
    check_val("rst_out_cmd", out_command, 312'(0));
    check_val("rst_parsed", 312'(stat_parsed), 312'(0));
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // AddOrder
    mk_add(64'h22001100, 8'h42, 32'h7d, 48'h7169, 64'h2653);
    sb.push_back(mk_cmd(8'd0, 8'h42, 64'h22001100, 32'h7d, 48'h7169, 64'h2653, 0, 0));
    send_msg(34);
    #1;
    check_val("add_valid", 312'(out_valid), 312'(1));
    check_val("add_type", 312'(out_command[303:296]), 312'(0));
    check_val("add_side", 312'(out_command[295:288]), 312'(8'h42));
    check_val("add_sym", 312'(out_command[191:128]), 312'(64'h7169));
    check_val("add_exec_canc", 312'(out_command[63:0]), 312'(0));
    check_val("add_parsed", 312'(stat_parsed), 312'(st(1)));
    idle(3);

    // Delete with backpressure
    out_ready = 1'b0;
    hdr(8'd14, 8'h29);
    push_le(64'd5, 8);
    sb.push_back(mk_cmd(8'd4, 0, 64'd5, 0, 0, 0, 0, 0));
    send_msg(14);
    #1 held = out_command;
    check_val("del_cmd", held, mk_cmd(8'd4, 0, 64'd5, 0, 0, 0, 0, 0));
    x0 = xfers;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check_val("bp_valid", 312'(out_valid), 312'(1));
      check_val("bp_stable", out_command, held);
      check_val("bp_in_ready", 312'(in_ready), 312'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check_val("bp_drained", 312'(out_valid), 312'(0));
    check_val("bp_one_xfer", 312'(xfers - x0), 312'(1));
    @(negedge clk);

    // Unknown type then ReduceSize
    hdr(8'd6, 8'h97);
    send_msg(6);
    #1 check_val("unk_stat", 312'(stat_unknown), 312'(st(1)));
    check_val("unk_no_out", 312'(out_valid), 312'(0));
    @(negedge clk);
    hdr(8'd18, 8'h25);
    push_le(64'd7, 8);
    push_le(64'd3, 4);
    sb.push_back(mk_cmd(8'd2, 0, 64'd7, 0, 0, 0, 0, 32'd3));
    send_msg(18);
    idle(3);

    // Length mismatch, then valid Modify and Exec
    hdr(8'd15, 8'h29);
    push_le(64'd9, 8);
    msg.push_back(8'hee);
    send_msg(15);
    #1 check_val("mm_dropped", 312'(stat_dropped), 312'(st(1)));
    check_val("mm_no_out", 312'(out_valid), 312'(0));
    @(negedge clk);
    hdr(8'd27, 8'h27);
    push_le(64'h0123456789abcdef, 8);
    push_le(64'h44, 4);
    push_le(64'h1122334455667788, 8);
    msg.push_back(8'h01);
    sb.push_back(mk_cmd(8'd3, 0, 64'h0123456789abcdef, 32'h44, 0, 64'h1122334455667788, 0, 0));
    send_msg(27);
    hdr(8'd26, 8'h23);
    push_le(64'hfeed, 8);
    push_le(64'h12345678, 4);
    push_le(64'hdeadbeefcafef00d, 8);
    sb.push_back(mk_cmd(8'd1, 0, 64'hfeed, 0, 0, 0, 32'h12345678, 0));
    send_msg(26);
    idle(3);

    // Runt length byte, then AddOrder with an invalid side
    send_byte(8'h01);
    mk_add(64'd77, 8'h41, 32'd1, 48'h414243444546, 64'd100);
    send_msg(34);
    #1 check_val("badside_no_out", 312'(out_valid), 312'(0));
    idle(3);
    #1;
    check_val("pre_rst_parsed", 312'(stat_parsed), 312'(st(5)));
    check_val("pre_rst_dropped", 312'(stat_dropped), 312'(st(3)));
    check_val("pre_rst_unknown", 312'(stat_unknown), 312'(st(1)));
    @(negedge clk);

    // Reset after 10 bytes of an AddOrder
    mk_add(64'd1234, 8'h53, 32'd9, 48'h4142, 64'd55);
    send_msg(10);
    #2 reset_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 312'(out_valid), 312'(0));
    check_val("mid_rst_in_ready", 312'(in_ready), 312'(1));
    check_val("mid_rst_parsed", 312'(stat_parsed), 312'(0));
    idle(2);
    reset_n = 1'b1;
    @(negedge clk);
    mk_add(64'habcdef, 8'h53, 32'd9, 48'h313233343536, 64'd55);
    sb.push_back(mk_cmd(8'd0, 8'h53, 64'habcdef, 32'd9, 48'h313233343536, 64'd55, 0, 0));
    send_msg(34);
    #1 check_val("post_rst_valid", 312'(out_valid), 312'(1));
    idle(3);
    #1;
    check_val("post_rst_parsed", 312'(stat_parsed), 312'(st(1)));
    check_val("post_rst_dropped", 312'(stat_dropped), 312'(st(0)));
    check_val("sb_empty", 312'(sb.size()), 312'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
